// File: rtl/div_issue_unit.sv
// Core-side issue/response controller for the integer Divider: resolves divide-by-zero
// and signed overflow locally, sequences all other requests through the Divider handshake.
module div_issue_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic [WIDTH-1:0] req_rs1_i,
    input  logic [WIDTH-1:0] req_rs2_i,
    input  logic [TAG_W-1:0] req_tag_i,
    input  logic             flush_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_result_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             rsp_error_o,
    output logic [WIDTH-1:0] div_divident_o,
    output logic [WIDTH-1:0] div_divisor_o,
    output logic             div_return_remainder_o,
    output logic             div_signed_o,
    output logic             div_start_o,
    input  logic             div_busy_i,
    input  logic             div_valid_i,
    input  logic             div_error_i,
    input  logic [WIDTH-1:0] div_result_i
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state;
    logic   accept;
    logic   div_by_zero;
    logic   sgn_ovf;

    // RISC-V defined results for the two cases the Divider never sees.
    function automatic logic [WIDTH-1:0] special_result(input logic             rem,
                                                        input logic [WIDTH-1:0] rs1,
                                                        input logic             zero);
        if (zero)
            return rem ? rs1 : ALL_ONES;
        else
            return rem ? '0 : rs1;
    endfunction

    assign req_ready_o = (state == IDLE) && !flush_i;
    assign accept      = req_valid_i && req_ready_o;
    assign div_by_zero = (req_rs2_i == '0);
    assign sgn_ovf     = !req_op_i[0] && (req_rs1_i == MIN_NEG) && (req_rs2_i == ALL_ONES);
    assign rsp_valid_o = (state == RESP);
    // Start is gated by the live busy flag so it can never collide with a running division.
    assign div_start_o = (state == ISSUE) && !div_busy_i;

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state                  <= IDLE;
            rsp_result_o           <= '0;
            rsp_tag_o              <= '0;
            rsp_error_o            <= 1'b0;
            div_divident_o         <= '0;
            div_divisor_o          <= '0;
            div_signed_o           <= 1'b0;
            div_return_remainder_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        div_divident_o         <= req_rs1_i;
                        div_divisor_o          <= req_rs2_i;
                        div_signed_o           <= ~req_op_i[0];
                        div_return_remainder_o <= req_op_i[1];
                        rsp_tag_o              <= req_tag_i;
                        rsp_error_o            <= 1'b0;
                        if (div_by_zero || sgn_ovf) begin
                            rsp_result_o <= special_result(req_op_i[1], req_rs1_i, div_by_zero);
                            state        <= RESP;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // Once start has gone out a result is owed, so a flush must drain it.
                    if (!div_busy_i)
                        state <= flush_i ? DRAIN : WAIT;
                    else if (flush_i)
                        state <= IDLE;
                end
                WAIT: begin
                    if (div_valid_i) begin
                        if (flush_i) begin
                            state <= IDLE;
                        end else begin
                            rsp_result_o <= div_result_i;
                            rsp_error_o  <= div_error_i;
                            state        <= RESP;
                        end
                    end else if (flush_i) begin
                        state <= DRAIN;
                    end
                end
                RESP: begin
                    if (flush_i || rsp_ready_i)
                        state <= IDLE;
                end
                DRAIN: begin
                    if (div_valid_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_issue_unit.sv
// Directed bench for div_issue_unit; the bench plays the Divider and the writeback stage.
module tb_div_issue_unit;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_op_i;
    logic [31:0] req_rs1_i;
    logic [31:0] req_rs2_i;
    logic [4:0]  req_tag_i;
    logic        flush_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_result_o;
    logic [4:0]  rsp_tag_o;
    logic        rsp_error_o;
    logic [31:0] div_divident_o;
    logic [31:0] div_divisor_o;
    logic        div_return_remainder_o;
    logic        div_signed_o;
    logic        div_start_o;
    logic        div_busy_i;
    logic        div_valid_i;
    logic        div_error_i;
    logic [31:0] div_result_i;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_issue_unit #(.WIDTH(32), .TAG_W(5)) dut (
        .clk                    (clk),
        .rst_i                  (rst_i),
        .req_valid_i            (req_valid_i),
        .req_ready_o            (req_ready_o),
        .req_op_i               (req_op_i),
        .req_rs1_i              (req_rs1_i),
        .req_rs2_i              (req_rs2_i),
        .req_tag_i              (req_tag_i),
        .flush_i                (flush_i),
        .rsp_valid_o            (rsp_valid_o),
        .rsp_ready_i            (rsp_ready_i),
        .rsp_result_o           (rsp_result_o),
        .rsp_tag_o              (rsp_tag_o),
        .rsp_error_o            (rsp_error_o),
        .div_divident_o         (div_divident_o),
        .div_divisor_o          (div_divisor_o),
        .div_return_remainder_o (div_return_remainder_o),
        .div_signed_o           (div_signed_o),
        .div_start_o            (div_start_o),
        .div_busy_i             (div_busy_i),
        .div_valid_i            (div_valid_i),
        .div_error_i            (div_error_i),
        .div_result_i           (div_result_i)
    );

    // Advance to just after the next rising edge; inputs change here, checks follow #1 later.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] t);
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_rs1_i   = a;
        req_rs2_i   = b;
        req_tag_i   = t;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        req_valid_i = 1'b0; req_op_i = 2'b00; req_rs1_i = '0; req_rs2_i = '0; req_tag_i = '0;
        flush_i = 1'b0; rsp_ready_i = 1'b1;
        div_busy_i = 1'b0; div_valid_i = 1'b0; div_error_i = 1'b0; div_result_i = '0;
        cyc(); cyc();
        #1;
        if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready_o); end
        checks++;
        if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid_o); end
        checks++;
        if (div_start_o !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", div_start_o); end
        checks++;
        if ({div_signed_o, div_return_remainder_o, rsp_error_o} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b expected 000", {div_signed_o, div_return_remainder_o, rsp_error_o});
        end
        checks++;
        if ({rsp_result_o, rsp_tag_o, div_divident_o, div_divisor_o} !== '0) begin
            errors++; $display("FAIL reset_data: got %h %h %h %h expected zeros", rsp_result_o, rsp_tag_o, div_divident_o, div_divisor_o);
        end
        checks++;
        cyc();
        rst_i = 1'b1;
        cyc();
    endtask

    task automatic test_divu();
        drive_req(2'b01, 32'd75, 32'd15, 5'd9);
        #1;
        if (req_ready_o !== 1'b1) begin errors++; $display("FAIL divu_ready: got %b expected 1", req_ready_o); end
        checks++;
        cyc();
        req_valid_i = 1'b0;
        #1;
        if (div_start_o !== 1'b1) begin errors++; $display("FAIL divu_start: got %b expected 1", div_start_o); end
        checks++;
        if ({div_signed_o, div_return_remainder_o} !== 2'b00) begin
            errors++; $display("FAIL divu_ctrl: got %b expected 00", {div_signed_o, div_return_remainder_o});
        end
        checks++;
        if (div_divident_o !== 32'd75 || div_divisor_o !== 32'd15) begin
            errors++; $display("FAIL divu_operands: got %0d/%0d expected 75/15", div_divident_o, div_divisor_o);
        end
        checks++;
        if (req_ready_o !== 1'b0) begin errors++; $display("FAIL divu_busy_ready: got %b expected 0", req_ready_o); end
        checks++;
        cyc();
        div_valid_i = 1'b1; div_result_i = 32'd5; div_error_i = 1'b0;
        #1;
        if (div_start_o !== 1'b0) begin errors++; $display("FAIL divu_single_start: got %b expected 0", div_start_o); end
        checks++;
        if (div_divident_o !== 32'd75) begin errors++; $display("FAIL divu_operand_hold: got %0d expected 75", div_divident_o); end
        checks++;
        cyc();
        div_valid_i = 1'b0;
        #1;
        if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'd5 || rsp_tag_o !== 5'd9 || rsp_error_o !== 1'b0) begin
            errors++; $display("FAIL divu_rsp: got v=%b r=%0d t=%0d e=%b expected v=1 r=5 t=9 e=0",
                               rsp_valid_o, rsp_result_o, rsp_tag_o, rsp_error_o);
        end
        checks++;
        cyc();
        #1;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            errors++; $display("FAIL divu_idle: got v=%b rdy=%b expected v=0 rdy=1", rsp_valid_o, req_ready_o);
        end
        checks++;
    endtask

    task automatic test_signed();
        logic [31:0] exp_r [2];
        logic [1:0]  ops [2];
        logic [31:0] a [2];
        logic [31:0] b [2];
        exp_r[0] = 32'd10; ops[0] = 2'b10; a[0] = 32'd75;         b[0] = 32'hFFFF_FFF3;
        exp_r[1] = 32'd3;  ops[1] = 2'b00; a[1] = 32'hFFFF_FBE6;  b[1] = 32'hFFFF_FED4;
        for (int i = 0; i < 2; i++) begin
            drive_req(ops[i], a[i], b[i], 5'(i + 20));
            cyc();
            req_valid_i = 1'b0;
            #1;
            if (div_start_o !== 1'b1 || div_signed_o !== 1'b1 || div_return_remainder_o !== ops[i][1]) begin
                errors++; $display("FAIL signed_ctrl[%0d]: got st=%b sg=%b rm=%b expected st=1 sg=1 rm=%b",
                                   i, div_start_o, div_signed_o, div_return_remainder_o, ops[i][1]);
            end
            checks++;
            cyc();
            div_valid_i = 1'b1; div_result_i = exp_r[i];
            cyc();
            div_valid_i = 1'b0;
            #1;
            if (rsp_valid_o !== 1'b1 || rsp_result_o !== exp_r[i] || rsp_tag_o !== 5'(i + 20)) begin
                errors++; $display("FAIL signed_rsp[%0d]: got v=%b r=%0d t=%0d expected v=1 r=%0d t=%0d",
                                   i, rsp_valid_o, rsp_result_o, rsp_tag_o, exp_r[i], i + 20);
            end
            checks++;
            cyc();
        end
    endtask

    task automatic test_shortcut();
        logic [1:0]  ops [3];
        logic [31:0] a [3];
        logic [31:0] b [3];
        logic [31:0] exp_r [3];
        ops[0] = 2'b00; a[0] = 32'd7;         b[0] = 32'd0;         exp_r[0] = 32'hFFFF_FFFF;
        ops[1] = 2'b10; a[1] = 32'h8000_0000; b[1] = 32'hFFFF_FFFF; exp_r[1] = 32'd0;
        ops[2] = 2'b11; a[2] = 32'd123;       b[2] = 32'd0;         exp_r[2] = 32'd123;
        div_error_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_req(ops[i], a[i], b[i], 5'(i + 1));
            #1;
            if (div_start_o !== 1'b0) begin errors++; $display("FAIL short_nostart_a[%0d]: got %b expected 0", i, div_start_o); end
            checks++;
            cyc();
            req_valid_i = 1'b0;
            #1;
            if (rsp_valid_o !== 1'b1 || rsp_result_o !== exp_r[i] || rsp_tag_o !== 5'(i + 1) || rsp_error_o !== 1'b0) begin
                errors++; $display("FAIL short_rsp[%0d]: got v=%b r=%h t=%0d e=%b expected v=1 r=%h t=%0d e=0",
                                   i, rsp_valid_o, rsp_result_o, rsp_tag_o, rsp_error_o, exp_r[i], i + 1);
            end
            checks++;
            if (div_start_o !== 1'b0) begin errors++; $display("FAIL short_nostart_b[%0d]: got %b expected 0", i, div_start_o); end
            checks++;
            cyc();
        end
        div_error_i = 1'b0;
    endtask

    task automatic test_busy();
        div_busy_i = 1'b1;
        drive_req(2'b01, 32'd100, 32'd10, 5'd12);
        cyc();
        req_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (div_start_o !== 1'b0 || req_ready_o !== 1'b0) begin
                errors++; $display("FAIL busy_hold[%0d]: got st=%b rdy=%b expected st=0 rdy=0", i, div_start_o, req_ready_o);
            end
            checks++;
            cyc();
        end
        div_busy_i = 1'b0;
        #1;
        if (div_start_o !== 1'b1) begin errors++; $display("FAIL busy_release_start: got %b expected 1", div_start_o); end
        checks++;
        cyc();
        div_busy_i = 1'b1;
        #1;
        if (div_start_o !== 1'b0) begin errors++; $display("FAIL busy_single_pulse: got %b expected 0", div_start_o); end
        checks++;
        div_valid_i = 1'b1; div_result_i = 32'd10; div_error_i = 1'b1;
        cyc();
        div_valid_i = 1'b0; div_error_i = 1'b0; div_busy_i = 1'b0;
        #1;
        if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'd10 || rsp_error_o !== 1'b1) begin
            errors++; $display("FAIL busy_rsp: got v=%b r=%0d e=%b expected v=1 r=10 e=1", rsp_valid_o, rsp_result_o, rsp_error_o);
        end
        checks++;
        cyc();
    endtask

    task automatic test_flush();
        flush_i = 1'b1;
        drive_req(2'b01, 32'd8, 32'd2, 5'd5);
        #1;
        if (req_ready_o !== 1'b0) begin errors++; $display("FAIL flush_idle_ready: got %b expected 0", req_ready_o); end
        checks++;
        cyc();
        req_valid_i = 1'b0; flush_i = 1'b0;
        #1;
        if (req_ready_o !== 1'b1 || div_start_o !== 1'b0) begin
            errors++; $display("FAIL flush_idle_noaccept: got rdy=%b st=%b expected rdy=1 st=0", req_ready_o, div_start_o);
        end
        checks++;
        div_busy_i = 1'b1;
        drive_req(2'b01, 32'd8, 32'd2, 5'd5);
        cyc();
        req_valid_i = 1'b0; flush_i = 1'b1;
        cyc();
        flush_i = 1'b0; div_busy_i = 1'b0;
        #1;
        if (req_ready_o !== 1'b1 || div_start_o !== 1'b0) begin
            errors++; $display("FAIL flush_issue: got rdy=%b st=%b expected rdy=1 st=0", req_ready_o, div_start_o);
        end
        checks++;
        drive_req(2'b01, 32'd50, 32'd5, 5'd6);
        cyc();
        req_valid_i = 1'b0;
        cyc(); cyc(); cyc();
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        #1;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b0) begin
            errors++; $display("FAIL flush_drain: got v=%b rdy=%b expected v=0 rdy=0", rsp_valid_o, req_ready_o);
        end
        checks++;
        cyc();
        div_valid_i = 1'b1; div_result_i = 32'd10;
        #1;
        if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL flush_drain_valid: got %b expected 0", rsp_valid_o); end
        checks++;
        cyc();
        div_valid_i = 1'b0;
        #1;
        if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
            errors++; $display("FAIL flush_return: got rdy=%b v=%b expected rdy=1 v=0", req_ready_o, rsp_valid_o);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        rsp_ready_i = 1'b0;
        drive_req(2'b01, 32'd100, 32'd7, 5'd3);
        cyc();
        req_valid_i = 1'b0;
        cyc();
        div_valid_i = 1'b1; div_result_i = 32'd14;
        cyc();
        div_valid_i = 1'b0; div_result_i = 32'd99;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'd14 || rsp_tag_o !== 5'd3 || req_ready_o !== 1'b0) begin
                errors++; $display("FAIL hold[%0d]: got v=%b r=%0d t=%0d rdy=%b expected v=1 r=14 t=3 rdy=0",
                                   i, rsp_valid_o, rsp_result_o, rsp_tag_o, req_ready_o);
            end
            checks++;
            cyc();
        end
        rsp_ready_i = 1'b1;
        cyc();
        drive_req(2'b00, 32'd1, 32'd0, 5'd4);
        #1;
        if (req_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", req_ready_o); end
        checks++;
        cyc();
        req_valid_i = 1'b0;
        #1;
        if (rsp_valid_o !== 1'b1 || rsp_result_o !== 32'hFFFF_FFFF || rsp_tag_o !== 5'd4) begin
            errors++; $display("FAIL b2b_rsp: got v=%b r=%h t=%0d expected v=1 r=ffffffff t=4", rsp_valid_o, rsp_result_o, rsp_tag_o);
        end
        checks++;
        cyc();
    endtask

    task automatic test_reset_mid();
        drive_req(2'b01, 32'd9, 32'd3, 5'd7);
        cyc();
        req_valid_i = 1'b0;
        cyc();
        rst_i = 1'b0;
        #1;
        if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0 || div_start_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_ctrl: got rdy=%b v=%b st=%b expected rdy=1 v=0 st=0", req_ready_o, rsp_valid_o, div_start_o);
        end
        checks++;
        if ({div_divident_o, div_divisor_o, rsp_tag_o, div_signed_o, div_return_remainder_o} !== '0) begin
            errors++; $display("FAIL rstmid_data: got %h %h %h %b %b expected zeros", div_divident_o, div_divisor_o,
                               rsp_tag_o, div_signed_o, div_return_remainder_o);
        end
        checks++;
        cyc();
        rst_i = 1'b1;
        cyc();
        div_valid_i = 1'b1; div_result_i = 32'd3;
        cyc();
        div_valid_i = 1'b0;
        #1;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            errors++; $display("FAIL rstmid_stale_valid: got v=%b rdy=%b expected v=0 rdy=1", rsp_valid_o, req_ready_o);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_divu();
        test_signed();
        test_shortcut();
        test_busy();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_issue_unit.md
# div_issue_unit

Issue and response controller on the core side of the integer-ALU `Divider`. Accepts DIV/DIVU/REM/REMU requests from the execute stage over a valid/ready handshake and resolves the RISC-V special cases (divide-by-zero, signed overflow) locally. All other requests are sequenced through the `Divider` start_flag/busy_o/valid_o protocol. Each tagged result is held until the writeback stage accepts it; requests are squashed on pipeline flush.

## Interface
- `WIDTH`, 32, operand/result width
- `TAG_W`, 5, request tag width (destination register index)

- `clk`  in  1  clock, all logic rising-edge
- `rst_i`  in  1  reset, asynchronous, active-low
- `req_valid_i`  in  1  request present
- `req_ready_o`  out  1  unit can accept a request
- `req_op_i`  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- `req_rs1_i` / `req_rs2_i`  in  WIDTH  dividend / divisor
- `req_tag_i`  in  TAG_W  request tag
- `flush_i`  in  1  squash in-flight request
- `rsp_valid_o`  out  1  result available
- `rsp_ready_i`  in  1  writeback accepts result
- `rsp_result_o`  out  WIDTH  quotient or remainder
- `rsp_tag_o`  out  TAG_W  tag of result
- `rsp_error_o`  out  1  divider reported error_o
- `div_divident_o` / `div_divisor_o`  out  WIDTH  to Divider operands
- `div_return_remainder_o`  out  1  1 remainder, 0 quotient
- `div_signed_o`  out  1  signed operation
- `div_start_o`  out  1  start_flag pulse
- `div_busy_i`, `div_valid_i`, `div_error_i`  in  1  from Divider
- `div_result_i`  in  WIDTH  Divider result_o

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE:
  - `req_ready_o`=1.
  - On accept (`req_valid_i & req_ready_o`), latch op, operands and tag.
  - `div_signed_o` = ~op[0]; `div_return_remainder_o` = op[1].
- Shortcuts (decided at accept, no divider access, next state RESP):
  - rs2==0: quotient = all-ones; remainder = rs1.
  - Signed op with rs1==0x80000000 and rs2==all-ones: quotient = rs1; remainder = 0.
  - `rsp_error_o`=0.
- Otherwise next state is ISSUE.
- ISSUE:
  - If `div_busy_i`=0, assert `div_start_o` for this single cycle and go to WAIT.
  - Else stay in ISSUE with `div_start_o`=0.
- WAIT:
  - On `div_valid_i`, capture `div_result_i` and `div_error_i` into the response registers and go to RESP.
- RESP:
  - `rsp_valid_o`=1.
  - On `rsp_ready_i`, go to IDLE.
- `div_*` operand and control outputs are registered and stay stable from ISSUE entry until WAIT exit.
- Flush (`flush_i`=1, highest priority):
  - IDLE: any same-cycle request is not accepted.
  - ISSUE (start not yet sent): go to IDLE.
  - ISSUE cycle where `div_start_o` fires: treated as WAIT, go to DRAIN.
  - WAIT: go to DRAIN.
  - RESP: response dropped, go to IDLE.
- DRAIN: wait for `div_valid_i`, discard the result, go to IDLE. No response is produced.
- Operand, tag and op handling:
  - The unit never modifies operands; signed handling is inside the `Divider`.
  - Tag passes through unmodified.

## Timing
- Reset values:
  - state = IDLE, so `req_ready_o`=1.
  - `rsp_valid_o`, `rsp_error_o`, `div_start_o`, `div_signed_o`, `div_return_remainder_o` = 0.
  - `rsp_result_o`, `rsp_tag_o`, `div_divident_o`, `div_divisor_o` = 0.
- Reset asserted mid-operation forces IDLE immediately. Any later `div_valid_i` arriving in IDLE is ignored.
- Shortcut latency: accept at cycle N, `rsp_valid_o`=1 at N+1.
- Divider path latency:
  - Accept at N.
  - `div_start_o` at N+1 (if `div_busy_i`=0).
  - `div_valid_i` sampled at M, `rsp_valid_o`=1 at M+1.
- Response hold: while `rsp_valid_o`=1 and `rsp_ready_i`=0, `rsp_result_o`, `rsp_tag_o` and `rsp_error_o` are held stable.
- Back-to-back requests: with `rsp_ready_i` held high, a new request can be accepted the cycle after the response handshake. `req_ready_o` is low from accept until return to IDLE.
- `div_start_o` is never high for two consecutive cycles, and never high while `div_busy_i`=1.

## Test plan
- DIVU 75/15, `rsp_ready_i`=1 -> one `div_start_o` pulse, then `rsp_result_o`=5, `rsp_tag_o`=request tag, `rsp_error_o`=0.
- REM 75 % -13 and DIV -1050/-300 -> results 10 and 3; `div_signed_o`=1 and `div_return_remainder_o` match op.
- DIV 7/0 and REM 0x80000000 % 0xFFFFFFFF -> results 0xFFFFFFFF and 0 at accept+1, with `div_start_o` never asserted.
- `div_busy_i` held high 4 cycles in ISSUE -> `div_start_o` delayed until the first cycle `div_busy_i`=0, then a single pulse.
- `flush_i` pulsed 3 cycles into WAIT -> no `rsp_valid_o`; `req_ready_o` returns to 1 the cycle after `div_valid_i`.
- DIVU 100/7 with `rsp_ready_i` low 5 cycles in RESP -> `rsp_result_o`=14 held stable with `req_ready_o`=0. `rst_i` pulled low during WAIT on a separate run -> all outputs at reset values immediately.
